// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller:
// FSM state encoding, default search width and settle-counter bounds.
package sar_search_pkg;

  localparam int unsigned SAR_WIDTH_DEF = 8;
  localparam int unsigned SETTLE_MAX    = 15;
  localparam int unsigned SETTLE_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Comparator flags are usable only when exactly one is set; X/Z fall to default.
  function automatic logic flags_onehot(input logic [2:0] flags);
    case (flags)
      3'b100, 3'b010, 3'b001: flags_onehot = 1'b1;
      default:                flags_onehot = 1'b0;
    endcase
  endfunction

endpackage : sar_search_pkg

// File: rtl/sar_search.sv
// Successive-approximation search controller: drives trial values into a
// magnitude comparator and resolves the unknown A operand one bit at a time.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int unsigned WIDTH         = SAR_WIDTH_DEF,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             Clk_In,
  input  logic             Reset_n_In,
  input  logic             Start_In,
  input  logic             A_gt_B_In,
  input  logic             A_eq_B_In,
  input  logic             A_lt_B_In,
  output logic             Comp_Enable_Out,
  output logic [WIDTH-1:0] Trial_Out,
  output logic [WIDTH-1:0] Result_Out,
  output logic             Done_Out,
  output logic             Busy_Out,
  output logic             Exact_Out,
  output logic             Error_Out
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CNT_W = SETTLE_W;
  localparam state_t      ST_FIRST = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_WAIT;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_trial;
  logic [WIDTH-1:0]   r_keep;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [CNT_W-1:0]   r_settle_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_done;
  logic               r_busy;
  logic               r_exact;
  logic               r_error;
  logic               r_comp_en;

  logic [WIDTH-1:0]   w_trial_nxt;
  logic [WIDTH-1:0]   w_keep_nxt;
  logic [IDX_W-1:0]   w_bit_idx_nxt;
  logic [CNT_W-1:0]   w_settle_cnt_nxt;
  logic [WIDTH-1:0]   w_result_nxt;
  logic               w_done_nxt;
  logic               w_busy_nxt;
  logic               w_exact_nxt;
  logic               w_error_nxt;
  logic               w_comp_en_nxt;

  logic               w_flags_ok;
  logic [WIDTH-1:0]   w_keep_upd;

  assign w_flags_ok = flags_onehot({A_gt_B_In, A_eq_B_In, A_lt_B_In});
  assign w_keep_upd = A_gt_B_In ? r_trial : r_keep;

  // State register
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (Start_In) begin
          w_state_nxt = ST_FIRST;
        end
      end
      ST_WAIT: begin
        if (r_settle_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (!w_flags_ok || A_eq_B_In || (r_bit_idx == '0)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_FIRST;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and output next values; results change only on DONE entry
  always_comb begin
    w_trial_nxt      = r_trial;
    w_keep_nxt       = r_keep;
    w_bit_idx_nxt    = r_bit_idx;
    w_settle_cnt_nxt = r_settle_cnt;
    w_result_nxt     = r_result;
    w_exact_nxt      = r_exact;
    w_error_nxt      = r_error;
    w_done_nxt       = (w_state_nxt == ST_DONE);
    w_busy_nxt       = (w_state_nxt != ST_IDLE);
    w_comp_en_nxt    = (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_SAMPLE);

    case (r_state)
      ST_IDLE: begin
        if (Start_In) begin
          w_trial_nxt      = WIDTH'(1) << (WIDTH - 1);
          w_keep_nxt       = '0;
          w_bit_idx_nxt    = IDX_W'(WIDTH - 1);
          w_settle_cnt_nxt = CNT_W'(SETTLE_CYCLES);
        end
      end
      ST_WAIT: begin
        w_settle_cnt_nxt = r_settle_cnt - CNT_W'(1);
      end
      ST_SAMPLE: begin
        if (!w_flags_ok) begin
          w_trial_nxt  = '0;
          w_result_nxt = '0;
          w_exact_nxt  = 1'b0;
          w_error_nxt  = 1'b1;
        end else if (A_eq_B_In) begin
          w_trial_nxt  = '0;
          w_result_nxt = r_trial;
          w_exact_nxt  = 1'b1;
          w_error_nxt  = 1'b0;
        end else if (r_bit_idx == '0) begin
          w_trial_nxt  = '0;
          w_keep_nxt   = w_keep_upd;
          w_result_nxt = w_keep_upd;
          w_exact_nxt  = 1'b0;
          w_error_nxt  = 1'b0;
        end else begin
          w_keep_nxt       = w_keep_upd;
          w_trial_nxt      = w_keep_upd | (WIDTH'(1) << (r_bit_idx - IDX_W'(1)));
          w_bit_idx_nxt    = r_bit_idx - IDX_W'(1);
          w_settle_cnt_nxt = CNT_W'(SETTLE_CYCLES);
        end
      end
      default: begin
        w_trial_nxt = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      r_trial      <= '0;
      r_keep       <= '0;
      r_bit_idx    <= '0;
      r_settle_cnt <= '0;
      r_result     <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_exact      <= 1'b0;
      r_error      <= 1'b0;
      r_comp_en    <= 1'b0;
    end else begin
      r_trial      <= w_trial_nxt;
      r_keep       <= w_keep_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_result     <= w_result_nxt;
      r_done       <= w_done_nxt;
      r_busy       <= w_busy_nxt;
      r_exact      <= w_exact_nxt;
      r_error      <= w_error_nxt;
      r_comp_en    <= w_comp_en_nxt;
    end
  end

  assign Comp_Enable_Out = r_comp_en;
  assign Trial_Out       = r_trial;
  assign Result_Out      = r_result;
  assign Done_Out        = r_done;
  assign Busy_Out        = r_busy;
  assign Exact_Out       = r_exact;
  assign Error_Out       = r_error;

endmodule : sar_search

// File: tb/tb_sar_search.sv
// Bench for sar_search: two instances (settle 1 and settle 0), each answered
// by a behavioural magnitude comparator that floats its flags when disabled.
module tb_sar_search;

  logic       clk;
  logic       rst_n;
  logic       start0, start1;
  logic [7:0] unk0, unk1;
  logic       dis0;

  logic       comp_en0, comp_en1;
  logic [7:0] trial0, trial1, result0, result1;
  logic       done0, done1, busy0, busy1, exact0, exact1, error0, error1;
  wire        gt0, eq0, lt0, gt1, eq1, lt1;
  wire        en0, en1;

  int total;
  int bad;
  int sel;

  typedef struct {
    logic [7:0] res;
    logic       exact;
    logic       err;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] trial_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural comparators: flags float when enable is low
  assign en0 = comp_en0 & ~dis0;
  assign en1 = comp_en1;
  assign gt0 = en0 ? (unk0 >  trial0) : 1'bz;
  assign eq0 = en0 ? (unk0 == trial0) : 1'bz;
  assign lt0 = en0 ? (unk0 <  trial0) : 1'bz;
  assign gt1 = en1 ? (unk1 >  trial1) : 1'bz;
  assign eq1 = en1 ? (unk1 == trial1) : 1'bz;
  assign lt1 = en1 ? (unk1 <  trial1) : 1'bz;

  sar_search #(.WIDTH(8), .SETTLE_CYCLES(1)) u_dut0 (
    .Clk_In(clk), .Reset_n_In(rst_n), .Start_In(start0),
    .A_gt_B_In(gt0), .A_eq_B_In(eq0), .A_lt_B_In(lt0),
    .Comp_Enable_Out(comp_en0), .Trial_Out(trial0), .Result_Out(result0),
    .Done_Out(done0), .Busy_Out(busy0), .Exact_Out(exact0), .Error_Out(error0)
  );

  sar_search #(.WIDTH(8), .SETTLE_CYCLES(0)) u_dut1 (
    .Clk_In(clk), .Reset_n_In(rst_n), .Start_In(start1),
    .A_gt_B_In(gt1), .A_eq_B_In(eq1), .A_lt_B_In(lt1),
    .Comp_Enable_Out(comp_en1), .Trial_Out(trial1), .Result_Out(result1),
    .Done_Out(done1), .Busy_Out(busy1), .Exact_Out(exact1), .Error_Out(error1)
  );

  logic [7:0] m_trial, m_result;
  logic       m_done, m_busy, m_exact, m_error;

  always_comb begin
    m_trial  = (sel == 1) ? trial1  : trial0;
    m_result = (sel == 1) ? result1 : result0;
    m_done   = (sel == 1) ? done1   : done0;
    m_busy   = (sel == 1) ? busy1   : busy0;
    m_exact  = (sel == 1) ? exact1  : exact0;
    m_error  = (sel == 1) ? error1  : error0;
  end

  // Reference search: binary descent over bits 7..0, stopping on equality
  function automatic exp_t model(input logic [7:0] u, input int settle);
    exp_t       e;
    logic [7:0] keep;
    logic [7:0] t;
    int         n;
    keep    = 8'h00;
    n       = 0;
    e.exact = 1'b0;
    e.err   = 1'b0;
    e.res   = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      t = keep | (8'h01 << b);
      trial_q.push_back(t);
      n++;
      if (u == t) begin
        e.exact = 1'b1;
        break;
      end
      if (u > t) keep = t;
    end
    e.res = e.exact ? t : keep;
    e.lat = n * (settle + 1);
    return e;
  endfunction

  task automatic run_search(input int s, input logic [7:0] u, input logic inject_err,
                            input string name);
    exp_t       e;
    exp_t       got;
    logic [7:0] last;
    logic [7:0] exp_t_val;
    logic [7:0] held;
    int         n;
    int         settle;
    settle = (s == 1) ? 0 : 1;
    trial_q.delete();
    if (inject_err) begin
      e.res = 8'h00; e.exact = 1'b0; e.err = 1'b1; e.lat = settle + 1;
      trial_q.push_back(8'h80);
    end else begin
      e = model(u, settle);
    end
    sb.push_back(e);
    sel = s;
    if (s == 1) unk1 = u; else unk0 = u;
    dis0 = inject_err;
    if (s == 1) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    n      = 0;
    last   = 8'h00;
    while (n < 200) begin
      if (m_trial != 8'h00 && m_trial != last) begin
        last = m_trial;
        exp_t_val = (trial_q.size() > 0) ? trial_q.pop_front() : 8'h00;
        total++;
        if (m_trial !== exp_t_val) begin
          bad++;
          $display("FAIL %s trial: got %02h want %02h", name, m_trial, exp_t_val);
        end
      end
      if (m_done === 1'b1) break;
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL %s timeout: no Done_Out within %0d edges", name, n);
      void'(sb.pop_front());
    end else begin
      got.res = m_result; got.exact = m_exact; got.err = m_error; got.lat = n;
      e = sb.pop_front();
      if (got.lat != e.lat) begin
        bad++;
        $display("FAIL %s latency: got %0d want %0d", name, got.lat, e.lat);
      end
      total++;
      if ({got.res, got.exact, got.err} !== {e.res, e.exact, e.err}) begin
        bad++;
        $display("FAIL %s result: got %02h/%b/%b want %02h/%b/%b", name,
                 got.res, got.exact, got.err, e.res, e.exact, e.err);
      end
      total++;
      if (trial_q.size() != 0) begin
        bad++;
        $display("FAIL %s trials: %0d expected trials not seen", name, trial_q.size());
      end
    end
    held = m_result;
    @(posedge clk);
    #1;
    total++;
    if ({m_done, m_busy, m_result} !== {1'b0, 1'b0, held}) begin
      bad++;
      $display("FAIL %s idle: done=%b busy=%b result=%02h want 0/0/%02h",
               name, m_done, m_busy, m_result, held);
    end
    dis0 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({comp_en0, trial0, result0, done0, busy0, exact0, error0} !== 21'd0) begin
      bad++;
      $display("FAIL reset0: got en=%b trial=%02h res=%02h d=%b b=%b x=%b e=%b want all 0",
               comp_en0, trial0, result0, done0, busy0, exact0, error0);
    end
    total++;
    if ({comp_en1, trial1, result1, done1, busy1, exact1, error1} !== 21'd0) begin
      bad++;
      $display("FAIL reset1: got en=%b trial=%02h res=%02h d=%b b=%b x=%b e=%b want all 0",
               comp_en1, trial1, result1, done1, busy1, exact1, error1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_held_reset();
    sel    = 0;
    unk0   = 8'h3C;
    start0 = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
    end
    #1;
    // 0x3C: 0x80 lt, 0x40 lt, then third trial 0x20 lands after edge 4
    total++;
    if ({busy0, trial0} !== {1'b1, 8'h20}) begin
      bad++;
      $display("FAIL held_start: busy=%b trial=%02h want 1/20", busy0, trial0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({comp_en0, trial0, result0, done0, busy0, exact0, error0} !== 21'd0) begin
      bad++;
      $display("FAIL async_reset: en=%b trial=%02h res=%02h d=%b b=%b want all 0",
               comp_en0, trial0, result0, done0, busy0);
    end
    start0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy0, comp_en0, trial0} !== 10'd0) begin
      bad++;
      $display("FAIL no_resume: busy=%b en=%b trial=%02h want 0/0/00", busy0, comp_en0, trial0);
    end
    run_search(0, 8'h3C, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0] u;
    for (int i = 0; i < 6; i++) begin
      u = 8'($urandom_range(0, 255));
      run_search(0, u, 1'b0, "b2b_s1");
      u = 8'($urandom_range(0, 255));
      run_search(1, u, 1'b0, "b2b_s0");
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    sel    = 0;
    start0 = 1'b0;
    start1 = 1'b0;
    unk0   = 8'h00;
    unk1   = 8'h00;
    dis0   = 1'b0;
    rst_n  = 1'b0;

    test_reset();
    run_search(0, 8'hA5, 1'b0, "a5");
    run_search(0, 8'h80, 1'b0, "eq_first");
    run_search(0, 8'h00, 1'b0, "zero");
    run_search(1, 8'hFF, 1'b0, "ff_fast");
    run_search(0, 8'h5A, 1'b1, "comp_disabled");
    run_search(1, 8'h01, 1'b0, "one_fast");
    test_start_held_reset();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sar_search

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller that finds an unknown 8-bit operand by driving trial values into the existing 8-bit magnitude comparator and consuming its greater/equal/less flags. It is the driving side of the comparator interface. It owns the comparator's enable and B-operand and reads back its three result outputs. It sits between a start/done control interface and one comparator instance whose A operand is the unknown value.

## Interface
- WIDTH, 8, search width; trial, result and comparator operand width
- SETTLE_CYCLES, 1, wait cycles after each new trial before flags are sampled (0..15)

- Clk_In  input  1  rising-edge clock
- Reset_n_In  input  1  reset; one clock, reset asynchronous and active-low
- Start_In  input  1  begin search; honoured only in IDLE
- A_gt_B_In  input  1  comparator flag: unknown > trial
- A_eq_B_In  input  1  comparator flag: unknown == trial
- A_lt_B_In  input  1  comparator flag: unknown < trial
- Comp_Enable_Out  output  1  comparator enable; high only in WAIT and SAMPLE
- Trial_Out  output  WIDTH  trial value to comparator B operand
- Result_Out  output  WIDTH  final result; held until next DONE
- Done_Out  output  1  one-cycle completion pulse
- Busy_Out  output  1  high in WAIT, SAMPLE and DONE
- Exact_Out  output  1  an equal flag ended the search; valid with Result_Out
- Error_Out  output  1  flags were not one-hot at a sample; valid with Result_Out

## Operation
- States: IDLE, WAIT, SAMPLE, DONE. Encoding is binary; IDLE is 0.
- IDLE with Start_In=1:
  - Load Trial = 1<<(WIDTH-1), Keep = 0, Bit_Idx = WIDTH-1, Settle_Cnt = SETTLE_CYCLES.
  - Go to WAIT, or straight to SAMPLE if SETTLE_CYCLES=0.
- WAIT: decrement Settle_Cnt each cycle. Go to SAMPLE in the cycle after Settle_Cnt reaches 1.
- SAMPLE: decide on flags at the closing edge, in this priority order:
  - Flags not exactly one-hot (including X/Z from a tri-stated comparator): Result=0, Exact=0, Error=1; go to DONE.
  - eq: Result=Trial, Exact=1; go to DONE.
  - gt: Keep=Trial (bit retained).
  - lt: Keep unchanged (bit cleared).
  - If Bit_Idx=0: Result=new Keep, Exact=0; go to DONE.
  - Otherwise: Trial = Keep | 1<<(Bit_Idx-1), decrement Bit_Idx, reload Settle_Cnt, go to WAIT (or SAMPLE if SETTLE_CYCLES=0).
- DONE: Done_Out=1 for exactly one cycle, then IDLE. Start_In is ignored in DONE, WAIT and SAMPLE.
- Trial_Out is 0 in IDLE and DONE.
- Result_Out, Exact_Out and Error_Out update only on DONE entry. They are held through IDLE.
- Unknown=0 never produces eq (trial is never 0). It ends with Result=0, Exact=0.

## Timing
- Reset (asynchronous, any state): state=IDLE; all outputs 0, including Result_Out; counters cleared. Deasserting reset mid-search does not resume the search.
- Each bit costs SETTLE_CYCLES+1 cycles.
- Worst-case latency, measured from the Start-sampling edge to the edge that raises Done_Out: WIDTH*(SETTLE_CYCLES+1). That is 16 edges at the defaults.
- An early eq at bit k finishes after (WIDTH-k)*(SETTLE_CYCLES+1) edges.
- Flags are sampled only at the edge closing SAMPLE. Flag changes during WAIT are ignored.
- Minimum Start-to-Start spacing is latency + 2 cycles (DONE cycle, then IDLE).

## Structure
- Shared package holds the state localparams (IDLE, WAIT, SAMPLE, DONE), the default WIDTH, and the SETTLE_CYCLES upper bound.
- No RTL sub-module; the block is a single FSM with its datapath registers.
- The bench instantiates the existing 8-bit comparator as the responder. Its Enable_In is tied to Comp_Enable_Out, Data_B_In to Trial_Out, and Data_A_In to the unknown value.

## Test plan
- Unknown=0xA5, SETTLE_CYCLES=1, Start pulsed:
  - Trials 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - Done_Out high 16 edges after start; Result=0xA5, Exact=1, Error=0.
- Unknown=0x80: eq on the first trial. Done after 2 edges; Result=0x80, Exact=1.
- Unknown=0x00: all lt. Done after 16 edges; Result=0x00, Exact=0, Error=0.
- Unknown=0xFF, SETTLE_CYCLES=0:
  - Trials 0x80..0xFF, one per cycle.
  - eq at 0xFF; Done after 8 edges; Result=0xFF, Exact=1.
- Comparator enable forced low (Z flags) during a search: Done at first SAMPLE exit; Result=0, Error=1.
- Start held high through a search, then Reset_n_In pulsed mid-search:
  - Second Start while busy is ignored.
  - On reset, all outputs drop to 0 immediately and state is IDLE.
  - A new Start afterwards completes normally.
